id_regfile_wb_sink: RTL

//  ID-stage register file; it is the receiving end of the writeback path (writeData_ID/rd_ID/RegWrite_WB).

---
 rtl/id_regfile_wb_sink.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/id_regfile_wb_sink.sv
// ID-stage register file, receiving end of the writeback path.
//
// Holds x0..x31 (x0 reads as zero, writes to it are dropped). Two combinational read ports with a
// same-cycle bypass from the WB write port; storage is written on the rising clock edge.
//
// Optional feature, macro REGFILE_SCOREBOARD_EN:
//   defined   - a per-register pending-write counter tracks in-flight writes (issue +1,
//               WB retire -1, EX squash -1) and stall_ID flags RAW hazards and full counters.
//   undefined - no counters, issue_ID/squash_EX ignored, stall_ID tied to 0.
//
// Ports:
//   clk, reset                        clock; asynchronous active-low reset
//   rs1_ID, rs2_ID                    source indices
//   readData1_ID, readData2_ID        source values (combinational, WB-bypassed)
//   issue_ID, rd_issue_ID             instruction with RegWrite leaving ID, and its destination
//   RegWrite_WB, rd_ID, writeData_ID  writeback port
//   squash_EX, rd_squash_EX           EX instruction with RegWrite killed by a flush
//   stall_ID                          hold ID: RAW hazard or destination counter full
module id_regfile_wb_sink #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PEND_W     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            rs1_ID,
  input  logic [4:0]            rs2_ID,
  output logic [DATA_WIDTH-1:0] readData1_ID,
  output logic [DATA_WIDTH-1:0] readData2_ID,
  input  logic                  issue_ID,
  input  logic [4:0]            rd_issue_ID,
  input  logic                  RegWrite_WB,
  input  logic [4:0]            rd_ID,
  input  logic [DATA_WIDTH-1:0] writeData_ID,
  input  logic                  squash_EX,
  input  logic [4:0]            rd_squash_EX,
  output logic                  stall_ID
);

  logic [DATA_WIDTH-1:0] regs_q [32];

  // Entry 0 is never written, so it stays at its reset value; the read path masks it anyway.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (RegWrite_WB && (rd_ID != 5'd0)) begin
      regs_q[rd_ID] <= writeData_ID;
    end
  end

  always_comb begin
    readData1_ID = regs_q[rs1_ID];
    if (rs1_ID == 5'd0) begin
      readData1_ID = '0;
    end else if (RegWrite_WB && (rd_ID == rs1_ID)) begin
      readData1_ID = writeData_ID;
    end
  end

  always_comb begin
    readData2_ID = regs_q[rs2_ID];
    if (rs2_ID == 5'd0) begin
      readData2_ID = '0;
    end else if (RegWrite_WB && (rd_ID == rs2_ID)) begin
      readData2_ID = writeData_ID;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  localparam int unsigned MaxCnt = (2 ** PEND_W) - 1;

  logic [PEND_W-1:0] cnt_q [32];
  logic [PEND_W-1:0] cnt_d [32];
  logic              underflow;
  logic              issue_at_max;
  logic              busy1, busy2, rd_full;

  // A write retiring (or being squashed) this cycle no longer blocks the reader.
  function automatic logic is_busy(logic [PEND_W-1:0] cnt, logic wb_hit, logic sq_hit);
    int rem;
    rem = int'(cnt) - (wb_hit ? 1 : 0) - (sq_hit ? 1 : 0);
    return rem > 0;
  endfunction

  always_comb begin
    int tmp;
    tmp       = 0;
    underflow = 1'b0;
    cnt_d[0]  = '0;
    for (int r = 1; r < 32; r++) begin
      tmp = int'(cnt_q[r]);
      if (issue_ID && (rd_issue_ID == 5'(r))) tmp = tmp + 1;
      if (RegWrite_WB && (rd_ID == 5'(r))) tmp = tmp - 1;
      if (squash_EX && (rd_squash_EX == 5'(r))) tmp = tmp - 1;
      // Both clamps only engage on a protocol violation.
      if (tmp < 0) begin
        underflow = 1'b1;
        tmp       = 0;
      end else if (tmp > int'(MaxCnt)) begin
        tmp = int'(MaxCnt);
      end
      cnt_d[r] = PEND_W'(tmp);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    busy1   = (rs1_ID != 5'd0) &&
              is_busy(cnt_q[rs1_ID], RegWrite_WB && (rd_ID == rs1_ID),
                      squash_EX && (rd_squash_EX == rs1_ID));
    busy2   = (rs2_ID != 5'd0) &&
              is_busy(cnt_q[rs2_ID], RegWrite_WB && (rd_ID == rs2_ID),
                      squash_EX && (rd_squash_EX == rs2_ID));
    rd_full = (rd_issue_ID != 5'd0) && (cnt_q[rd_issue_ID] == PEND_W'(MaxCnt));
    issue_at_max = issue_ID && rd_full;
  end

  assign stall_ID = busy1 | busy2 | rd_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!underflow);
      assert (!issue_at_max);
    end
  end
`else
  assign stall_ID = 1'b0;

  logic unused_sb;
  assign unused_sb = ^{issue_ID, rd_issue_ID, squash_EX, rd_squash_EX};
`endif

endmodule
